seq_magnitude_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator that generalises our gate-level equality and greater-than comparators. It takes two WIDTH-bit operands and scans them MSB-first, DIGIT bits per clock, with early termination on the first differing digit. It reports equal, greater-than and less-than for unsigned or two's-complement operands. It sits between operand registers and control logic as a start/done coprocessor, so wide compares do not need a long combinational chain.

---
 rtl/seq_magnitude_comparator.sv | 102 ++++++++++
 tb/tb_seq_magnitude_comparator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans two captured operands MSB-first,
// DIGIT bits per clock, stopping at the first differing digit.
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic [WIDTH-1:0] w_sign;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;

    // Flipping the sign bit maps two's complement onto offset binary,
    // so the unsigned digit scan yields the signed ordering.
    assign w_sign = signed_mode ? SIGN_BIT : '0;
    assign w_da   = r_a[WIDTH-1 -: DIGIT];
    assign w_db   = r_b[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a ^ w_sign;
                        r_b     <= b ^ w_sign;
                        r_cnt   <= CNT_LOAD;
                        r_eq    <= 1'b0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_da != w_db) begin
                        r_gt    <= (w_da > w_db);
                        r_lt    <= (w_da < w_db);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_cnt == '0) begin
                        r_eq    <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_a   <= r_a << DIGIT;
                        r_b   <= r_b << DIGIT;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign done  = r_done;
    assign eq    = r_eq;
    assign gt    = r_gt;
    assign lt    = r_lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed and parameter-sweep checks for seq_magnitude_comparator.
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // main instance, 16/2
    logic        start = 1'b0, sm = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        ready, done, eq, gt, lt;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(sm),
        .a(a), .b(b), .ready(ready), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    // sweep instances
    logic        s_start = 1'b0, s_sm = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [31:0] a2 = '0, b2 = '0;
    logic        rdy0, dn0, eq0, gt0, lt0;
    logic        rdy1, dn1, eq1, gt1, lt1;
    logic        rdy2, dn2, eq2, gt2, lt2;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) s0 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .signed_mode(s_sm),
        .a(a0), .b(b0), .ready(rdy0), .done(dn0), .eq(eq0), .gt(gt0), .lt(lt0)
    );
    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) s1 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .signed_mode(s_sm),
        .a(a1), .b(b1), .ready(rdy1), .done(dn1), .eq(eq1), .gt(gt1), .lt(lt1)
    );
    seq_magnitude_comparator #(.WIDTH(32), .DIGIT(4)) s2 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .signed_mode(s_sm),
        .a(a2), .b(b2), .ready(rdy2), .done(dn2), .eq(eq2), .gt(gt2), .lt(lt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {eq,gt,lt} from a plain integer compare
    function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input int w, input bit sgn);
        longint xs = longint'(x);
        longint ys = longint'(y);
        if (sgn && x[w-1]) xs = xs - (64'sd1 <<< w);
        if (sgn && y[w-1]) ys = ys - (64'sd1 <<< w);
        if (xs == ys) return 3'b100;
        if (xs > ys)  return 3'b010;
        return 3'b001;
    endfunction

    // index of the first differing digit; all-equal gives the last digit
    function automatic int first_diff(input logic [31:0] x, input logic [31:0] y,
                                      input int w, input int dg);
        logic [31:0] dx = x ^ y;
        logic [31:0] mask = (32'd1 << dg) - 32'd1;
        if (dg == 32) mask = '1;
        for (int k = 0; k < w / dg; k++)
            if (((dx >> (w - dg * (k + 1))) & mask) != 0) return k;
        return w / dg - 1;
    endfunction

    function automatic logic [31:0] bias(input logic [31:0] x, input int w);
        int unsigned r = $urandom_range(0, 7);
        logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (r == 0) return x;
        if (r == 1) return x ^ (32'd1 << $urandom_range(0, w - 1));
        return $urandom() & m;
    endfunction

    initial begin
        int pulses;
        int lat0, lat1, lat2;
        int np0, np1, np2;
        logic [2:0] f0, f1, f2;
        logic [31:0] x, y;

        // reset state
        #2;
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", {eq, gt, lt}, 3'b000);
        tick();
        reset_n = 1'b1;
        tick();

        // unsigned equal, worst-case latency
        a = 16'h1234; b = 16'h1234; sm = 1'b0; start = 1'b1;
        tick();                 // edge 0
        start = 1'b0;
        chk("eq_busy", ready, 1'b0);
        pulses = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (done) pulses++;
        end
        chk("eq_early_done", pulses, 0);
        tick();                 // edge 8
        chk("eq_done", done, 1'b1);
        chk("eq_flags", {eq, gt, lt}, 3'b100);
        chk("eq_ready_in_done", ready, 1'b0);
        tick();                 // edge 9
        chk("eq_done_end", done, 1'b0);
        chk("eq_ready_back", ready, 1'b1);
        chk("eq_flags_hold", {eq, gt, lt}, 3'b100);

        // early exit, unsigned
        a = 16'h8000; b = 16'h7FFF; sm = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("u_early_done", done, 1'b1);
        chk("u_early_flags", {eq, gt, lt}, 3'b010);
        tick();
        chk("u_early_ready", ready, 1'b1);

        // early exit, signed
        sm = 1'b1; start = 1'b1;
        tick(); start = 1'b0; sm = 1'b0;
        tick();
        chk("s_early_done", done, 1'b1);
        chk("s_early_flags", {eq, gt, lt}, 3'b001);
        tick();

        // late difference, then flag hold and clear
        a = 16'h0001; b = 16'h0002; sm = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (done) pulses++;
        end
        chk("late_early_done", pulses, 0);
        tick();
        chk("late_done", done, 1'b1);
        chk("late_flags", {eq, gt, lt}, 3'b001);
        tick();
        pulses = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            if (done || {eq, gt, lt} != 3'b001) pulses++;
        end
        chk("late_hold", pulses, 0);
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        tick(); start = 1'b0;
        chk("late_clear", {eq, gt, lt}, 3'b000);
        for (int e = 0; e < 9; e++) tick();

        // busy protection: start held, operands changed during SCAN
        a = 16'h00E0; b = 16'h00F0; sm = 1'b0; start = 1'b1;
        tick();                 // edge 0, d = 5
        a = 16'hFFFF; b = 16'h0000;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (done) pulses++;
            if (e == 6) begin
                chk("busy_done1", done, 1'b1);
                chk("busy_flags1", {eq, gt, lt}, 3'b001);
            end
            if (e == 7) chk("busy_ready", ready, 1'b1);
            if (e == 8) begin
                chk("busy_accept2", ready, 1'b0);
                chk("busy_clear2", {eq, gt, lt}, 3'b000);
                start = 1'b0;
            end
            if (e == 9) begin
                chk("busy_done2", done, 1'b1);
                chk("busy_flags2", {eq, gt, lt}, 3'b010);
            end
        end
        chk("busy_pulses", pulses, 2);

        // reset in the third SCAN cycle
        a = 16'h5555; b = 16'h5555; start = 1'b1;
        tick(); start = 1'b0;   // edge 0
        tick(); tick();         // edges 1, 2
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_ready", ready, 1'b1);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_flags", {eq, gt, lt}, 3'b000);
        pulses = 0;
        tick(); if (done) pulses++;
        tick(); if (done) pulses++;
        reset_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (done) pulses++;
        end
        chk("rst_mid_nopulse", pulses, 0);
        a = 16'h0010; b = 16'h0020; start = 1'b1;
        tick(); start = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        chk("rst_after_pre", done, 1'b0);
        tick();
        chk("rst_after_done", done, 1'b1);
        chk("rst_after_flags", {eq, gt, lt}, 3'b001);
        tick(); tick();

        // parameter sweep, three instances in lockstep
        for (int p = 0; p < 1000; p++) begin
            x = $urandom() & 32'hFF;  a0 = x[7:0]; y = bias(x, 8);  b0 = y[7:0];
            x = $urandom() & 32'hFF;  a1 = x[7:0]; y = bias(x, 8);  b1 = y[7:0];
            x = $urandom();           a2 = x;      b2 = bias(x, 32);
            for (int m = 0; m < 2; m++) begin
                s_sm = m[0]; s_start = 1'b1;
                tick(); s_start = 1'b0; s_sm = ~m[0];
                lat0 = 0; lat1 = 0; lat2 = 0; np0 = 0; np1 = 0; np2 = 0;
                f0 = 'x; f1 = 'x; f2 = 'x;
                for (int c = 1; c <= 40; c++) begin
                    tick();
                    if (dn0) begin np0++; if (lat0 == 0) begin lat0 = c; f0 = {eq0, gt0, lt0}; end end
                    if (dn1) begin np1++; if (lat1 == 0) begin lat1 = c; f1 = {eq1, gt1, lt1}; end end
                    if (dn2) begin np2++; if (lat2 == 0) begin lat2 = c; f2 = {eq2, gt2, lt2}; end end
                    if (lat0 != 0 && lat1 != 0 && lat2 != 0 && rdy0 && rdy1 && rdy2) break;
                end
                chk("sw88_flags", f0, model({24'd0, a0}, {24'd0, b0}, 8, m[0]));
                chk("sw88_lat", lat0, first_diff({24'd0, a0}, {24'd0, b0}, 8, 8) + 1);
                chk("sw88_pulses", np0, 1);
                chk("sw81_flags", f1, model({24'd0, a1}, {24'd0, b1}, 8, m[0]));
                chk("sw81_lat", lat1, first_diff({24'd0, a1}, {24'd0, b1}, 8, 1) + 1);
                chk("sw81_pulses", np1, 1);
                chk("sw324_flags", f2, model(a2, b2, 32, m[0]));
                chk("sw324_lat", lat2, first_diff(a2, b2, 32, 4) + 1);
                chk("sw324_pulses", np2, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
